// File: rtl/nlprg_pkg.sv
// Shared definitions for the nonlinear pseudo-random generator family:
// width limits, FSM states and the primitive-polynomial tap table.
package nlprg_pkg;

   localparam int N_MIN = 3;
   localparam int N_MAX = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nlprg_state_e;

   // Bit (t-1) is set for every polynomial term x^t; the x^n term always sits at bit n-1.
   function automatic logic [31:0] nlprg_taps(input int n);
      logic [31:0] taps;
      case (n)
         3:       taps = 32'h0000_0006;
         4:       taps = 32'h0000_000C;
         5:       taps = 32'h0000_0014;
         6:       taps = 32'h0000_0030;
         7:       taps = 32'h0000_0060;
         8:       taps = 32'h0000_00B8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         11:      taps = 32'h0000_0500;
         12:      taps = 32'h0000_0829;
         13:      taps = 32'h0000_100D;
         14:      taps = 32'h0000_2015;
         15:      taps = 32'h0000_6000;
         16:      taps = 32'h0000_D008;
         17:      taps = 32'h0001_2000;
         18:      taps = 32'h0002_0400;
         19:      taps = 32'h0004_0023;
         20:      taps = 32'h0009_0000;
         21:      taps = 32'h0014_0000;
         22:      taps = 32'h0030_0000;
         23:      taps = 32'h0042_0000;
         24:      taps = 32'h00E1_0000;
         25:      taps = 32'h0120_0000;
         26:      taps = 32'h0200_0023;
         27:      taps = 32'h0400_0013;
         28:      taps = 32'h0900_0000;
         29:      taps = 32'h1400_0000;
         30:      taps = 32'h2000_0029;
         31:      taps = 32'h4800_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/nlprg_core.sv
// Combinational successor function: Fibonacci LFSR step with the all-zero
// state spliced in between 100..0 and 00..01, giving a full 2^N cycle.
module nlprg_core
   import nlprg_pkg::*;
#(
   parameter int N = 11
) (
   input  logic [N-1:0] s,
   output logic [N-1:0] s_nxt
);

   localparam logic [31:0]  TAPS_ALL = nlprg_taps(N);
   localparam logic [N-1:0] TAPS     = TAPS_ALL[N-1:0];

   logic fb;

   // Flipping the feedback when the low N-1 bits are zero routes 100..0 -> 0 -> 00..01.
   always_comb begin
      fb    = (^(s & TAPS)) ^ (s[N-2:0] == '0);
      s_nxt = {s[N-2:0], fb};
   end

endmodule

// File: rtl/nlprg_gen.sv
// Parametrised nonlinear pseudo-random generator with seed load, valid/ready
// output stream, period-wrap pulse and optional one-shot (single period) mode.
module nlprg_gen
   import nlprg_pkg::*;
#(
   parameter int N           = 11,
   parameter bit ONESHOT_DEF = 1'b0
) (
   input  logic         ck,
   input  logic         rst_n,
   input  logic         en,
   input  logic         mode,
   input  logic         ld,
   input  logic [N-1:0] seed,
   output logic [N-1:0] o,
   output logic         o_vld,
   input  logic         o_rdy,
   output logic         wrap,
   output logic         done
);

   if (N < N_MIN || N > N_MAX) begin : g_bad_width
      $error("nlprg_gen: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
   end

   nlprg_state_e state_q, state_d;
   logic [N-1:0] s_q, s_d;
   logic [N-1:0] start_q, start_d;
   logic         mode_q, mode_d;
   logic         wrap_q, wrap_d;
   logic [N-1:0] s_nxt;
   logic         xfer;
   logic         hit_start;

   nlprg_core #(
      .N(N)
   ) u_core (
      .s     (s_q),
      .s_nxt (s_nxt)
   );

   assign o_vld     = (state_q == RUN) && en;
   assign xfer      = o_vld && o_rdy;
   assign hit_start = (s_nxt == start_q);
   assign o         = s_q;
   assign wrap      = wrap_q;
   assign done      = (state_q == DONE);

   // Load beats everything; a transfer coincident with load is consumed without advancing.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      start_d = start_q;
      mode_d  = mode_q;
      wrap_d  = 1'b0;

      if (ld) begin
         s_d     = seed;
         start_d = seed;
         mode_d  = mode;
         state_d = en ? RUN : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!en) begin
                  state_d = IDLE;
               end else if (xfer) begin
                  s_d    = s_nxt;
                  wrap_d = hit_start;
                  if (mode_q && hit_start) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         start_q <= '0;
         mode_q  <= ONESHOT_DEF;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         start_q <= start_d;
         mode_q  <= mode_d;
         wrap_q  <= wrap_d;
      end
   end

endmodule
